// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed I/Q FIR: one multiplier/accumulator steps through the I taps,
// then the Q taps, for every accepted input strobe, then emits the rounded pair.
module fir_mac_sequencer #(
  parameter int  DW   = 24,
  parameter int  TAPS = 13,
  parameter int  CW   = 16,
  parameter real COEF [TAPS] = '{0.0, 0.009, 0.0, -0.0572, 0.0, 0.2984, 0.4996,
                                 0.2984, 0.0, -0.0572, 0.0, 0.009, 0.0}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] iin,
  input  logic [DW-1:0] qin,
  output logic [DW-1:0] iout,
  output logic [DW-1:0] qout,
  output logic          out_valid,
  output logic          busy,
  output logic          overrun,
  input  logic          clr_ovr
);

  localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PW = DW + CW;
  localparam int AW = DW + CW + $clog2(TAPS);

  localparam logic signed [AW-1:0] ONE  = AW'(64'sd1);
  localparam logic signed [AW-1:0] RND  = ONE <<< (CW - 2);
  localparam logic signed [AW-1:0] OMAX = (ONE <<< (DW - 1)) - ONE;
  localparam logic signed [AW-1:0] OMIN = -(ONE <<< (DW - 1));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC_I = 2'd1,
    MAC_Q = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Real coefficient to signed Q1.(CW-1): round half away from zero, then clip.
  function automatic logic signed [CW-1:0] quant(input real r);
    real    s;
    longint v;
    longint cmax;
    longint cmin;
    cmax = (64'sd1 <<< (CW - 1)) - 64'sd1;
    cmin = -(64'sd1 <<< (CW - 1));
    s = r * (2.0 ** (CW - 1));
    if (s >= 0.0) v = longint'($rtoi(s + 0.5));
    else          v = -longint'($rtoi(0.5 - s));
    if (v > cmax)      v = cmax;
    else if (v < cmin) v = cmin;
    return CW'(v);
  endfunction

  // Drop CW-1 fraction bits with round-half-up, then saturate to DW bits.
  function automatic logic [DW-1:0] round_sat(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] r;
    r = (a + RND) >>> (CW - 1);
    if (r > OMAX)      return OMAX[DW-1:0];
    else if (r < OMIN) return OMIN[DW-1:0];
    else               return r[DW-1:0];
  endfunction

  state_t                 state_r, state_s;
  logic [KW-1:0]          k_r;
  logic signed [DW-1:0]   d_i_r [TAPS];
  logic signed [DW-1:0]   d_q_r [TAPS];
  logic signed [AW-1:0]   acc_i_r, acc_q_r;
  logic [DW-1:0]          iout_r, qout_r;
  logic                   out_valid_r, overrun_r;
  logic signed [CW-1:0]   coef_s [TAPS];
  logic signed [DW-1:0]   sample_s;
  logic signed [CW-1:0]   coef_sel_s;
  logic signed [PW-1:0]   prod_s;
  logic                   last_tap_s;

  genvar g;
  for (g = 0; g < TAPS; g++) begin : g_coef
    localparam logic signed [CW-1:0] C = quant(COEF[g]);
    assign coef_s[g] = C;
  end

  assign last_tap_s = (k_r == KW'(TAPS - 1));
  assign busy       = (state_r != IDLE);
  assign iout       = iout_r;
  assign qout       = qout_r;
  assign out_valid  = out_valid_r;
  assign overrun    = overrun_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic: I taps, then Q taps, then one output cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (en) state_s = MAC_I; else state_s = IDLE;
      MAC_I:   if (last_tap_s) state_s = MAC_Q; else state_s = MAC_I;
      MAC_Q:   if (last_tap_s) state_s = OUT; else state_s = MAC_Q;
      OUT:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Shared multiplier: operand mux follows the channel being accumulated.
  always_comb begin
    if (state_r == MAC_Q) sample_s = d_q_r[k_r];
    else                  sample_s = d_i_r[k_r];
    coef_sel_s = coef_s[k_r];
    prod_s     = PW'(sample_s) * PW'(coef_sel_s);
  end

  // Delay lines, accumulators, tap index and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        d_i_r[k] <= '0;
        d_q_r[k] <= '0;
      end
      acc_i_r     <= '0;
      acc_q_r     <= '0;
      k_r         <= '0;
      iout_r      <= '0;
      qout_r      <= '0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (en) begin
            for (int k = TAPS - 1; k > 0; k--) begin
              d_i_r[k] <= d_i_r[k-1];
              d_q_r[k] <= d_q_r[k-1];
            end
            d_i_r[0] <= iin;
            d_q_r[0] <= qin;
            acc_i_r  <= '0;
            acc_q_r  <= '0;
            k_r      <= '0;
          end
        end
        MAC_I: begin
          acc_i_r <= acc_i_r + AW'(prod_s);
          k_r     <= last_tap_s ? {KW{1'b0}} : k_r + KW'(1);
        end
        MAC_Q: begin
          acc_q_r <= acc_q_r + AW'(prod_s);
          k_r     <= last_tap_s ? {KW{1'b0}} : k_r + KW'(1);
        end
        OUT: begin
          iout_r      <= round_sat(acc_i_r);
          qout_r      <= round_sat(acc_q_r);
          out_valid_r <= 1'b1;
        end
        default: begin
          k_r <= '0;
        end
      endcase
    end
  end

  // Sticky overrun; a new drop outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              overrun_r <= 1'b0;
    else if (en && busy)     overrun_r <= 1'b1;
    else if (clr_ovr)        overrun_r <= 1'b0;
    else                     overrun_r <= overrun_r;
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Randomized bench for fir_mac_sequencer against a sample-history FIR model.
module tb_fir_mac_sequencer;

  localparam int DW   = 24;
  localparam int TAPS = 13;
  localparam int CW   = 16;
  localparam int SEQ  = 2 * TAPS + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          clr_ovr = 1'b0;
  logic [DW-1:0] iin = '0;
  logic [DW-1:0] qin = '0;
  logic [DW-1:0] iout, qout;
  logic          out_valid, busy, overrun;

  fir_mac_sequencer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .iin(iin), .qin(qin),
    .iout(iout), .qout(qout), .out_valid(out_valid), .busy(busy),
    .overrun(overrun), .clr_ovr(clr_ovr)
  );

  always #5 clk = ~clk;

  int     total = 0;
  int     bad = 0;
  longint cyc = 0;
  longint last_acc = -1000;
  bit     ovr_exp = 1'b0;
  int     cf [TAPS] = '{0, 295, 0, -1874, 0, 9778, 16371, 9778, 0, -1874, 0, 295, 0};
  longint hi [TAPS];
  longint hq [TAPS];
  longint exp_i[$], exp_q[$], cap_i[$], cap_q[$];

  task automatic chk(input string tag, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Direct-form FIR over the accepted sample history, round half up, saturate.
  function automatic longint ref_fir(input bit qch);
    longint s = 0;
    longint r;
    for (int k = 0; k < TAPS; k++) s += (qch ? hq[k] : hi[k]) * cf[k];
    r = (s + 64'sd16384) >>> 15;
    if (r > 64'sd8388607)       r = 64'sd8388607;
    else if (r < -64'sd8388608) r = -64'sd8388608;
    return r;
  endfunction

  function automatic longint rnd_s();
    bit [31:0]            b;
    logic signed [DW-1:0] t;
    b = $urandom;
    t = b[DW-1:0];
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      hi[k] = 0;
      hq[k] = 0;
    end
    exp_i.delete(); exp_q.delete(); cap_i.delete(); cap_q.delete();
    last_acc = -1000;
    ovr_exp  = 1'b0;
  endtask

  // A strobe is dropped if the engine is still busy from the previous accepted one.
  task automatic strobe(input longint i, input longint q, input bit clr);
    en = 1'b1; iin = DW'(i); qin = DW'(q); clr_ovr = clr;
    if (cyc + 1 - last_acc > SEQ) begin
      for (int k = TAPS - 1; k > 0; k--) begin
        hi[k] = hi[k-1];
        hq[k] = hq[k-1];
      end
      hi[0] = i;
      hq[0] = q;
      exp_i.push_back(ref_fir(1'b0));
      exp_q.push_back(ref_fir(1'b1));
      last_acc = cyc + 1;
      if (clr) ovr_exp = 1'b0;
    end else begin
      ovr_exp = 1'b1;
    end
    step();
    en = 1'b0; clr_ovr = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_ovr = 1'b1;
    ovr_exp = 1'b0;
    step();
    clr_ovr = 1'b0;
  endtask

  // Output monitor: every out_valid must match the next expected model result.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      cap_i.push_back($signed(iout));
      cap_q.push_back($signed(qout));
      if (exp_i.size() == 0) chk("spurious_valid", out_valid, 0);
      else begin
        chk("iout", $signed(iout), exp_i.pop_front());
        chk("qout", $signed(qout), exp_q.pop_front());
      end
    end
  end

  initial begin
    int busy_n;
    int val_n;
    int gap;
    model_reset();

    #2 rst_n = 1'b0;
    #1;
    chk("rst_iout", iout, 0);
    chk("rst_qout", qout, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Timing of one sequence and back-to-back acceptance in the out_valid cycle.
    busy_n = 0; val_n = 0;
    strobe(rnd_s(), rnd_s(), 1'b0);
    for (int j = 0; j < SEQ; j++) begin
      busy_n += int'(busy);
      val_n  += int'(out_valid);
      step();
    end
    chk("busy_cycles", busy_n, SEQ);
    chk("early_valid", val_n, 0);
    chk("valid_cycle", out_valid, 1);
    chk("busy_in_valid", busy, 0);
    strobe(rnd_s(), rnd_s(), 1'b0);
    chk("busy_restart", busy, 1);
    chk("ovr_none", overrun, 0);
    idle(SEQ + 3);

    // Asynchronous reset in the middle of the Q pass aborts the sequence.
    strobe(rnd_s(), rnd_s(), 1'b0);
    idle(19);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_iout", iout, 0);
    chk("abort_qout", qout, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ovr", overrun, 0);
    model_reset();
    @(negedge clk);
    step();
    rst_n = 1'b1;
    idle(SEQ + 5);
    chk("abort_no_valid", cap_i.size(), 0);

    // Impulse response.
    strobe(64'sd4194304, 0, 1'b0);
    idle(SEQ);
    for (int n = 0; n < TAPS - 1; n++) begin
      strobe(0, 0, 1'b0);
      idle(SEQ);
    end
    idle(3);
    chk("imp_count", cap_i.size(), TAPS);
    chk("imp_k6", cap_i[6], 64'sd2095488);
    chk("imp_k3", cap_i[3], -64'sd239872);

    // DC gain.
    cap_i.delete(); cap_q.delete();
    for (int n = 0; n < 16; n++) begin
      strobe(64'sd4194304, -64'sd4194304, 1'b0);
      idle(SEQ);
    end
    idle(3);
    chk("dc_i", cap_i[cap_i.size()-1], 64'sd4194432);
    chk("dc_q", cap_q[cap_q.size()-1], -64'sd4194432);

    // Full-scale DC must saturate.
    cap_i.delete(); cap_q.delete();
    for (int n = 0; n < 16; n++) begin
      strobe(64'sd8388607, -64'sd8388608, 1'b0);
      idle(SEQ);
    end
    idle(3);
    chk("sat_i", cap_i[cap_i.size()-1], 64'sd8388607);
    chk("sat_q", cap_q[cap_q.size()-1], -64'sd8388608);

    // Overrun: dropped sample, clear, and set-beats-clear.
    clr_pulse();
    chk("ovr_clear0", overrun, 0);
    strobe(rnd_s(), rnd_s(), 1'b0);
    idle(4);
    strobe(rnd_s(), rnd_s(), 1'b0);
    chk("ovr_set", overrun, 1);
    idle(SEQ);
    strobe(rnd_s(), rnd_s(), 1'b0);
    idle(SEQ + 1);
    clr_pulse();
    chk("ovr_cleared", overrun, 0);
    strobe(rnd_s(), rnd_s(), 1'b0);
    idle(3);
    strobe(rnd_s(), rnd_s(), 1'b1);
    chk("ovr_set_wins", overrun, 1);
    idle(SEQ + 3);

    // Random samples with random spacing, some too close and dropped.
    clr_pulse();
    for (int n = 0; n < 25; n++) begin
      gap = int'($urandom_range(34, 20));
      strobe(rnd_s(), rnd_s(), 1'b0);
      idle(gap - 1);
    end
    idle(SEQ + 3);
    chk("rand_ovr", overrun, longint'(ovr_exp));
    chk("drain", exp_i.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
